fp_normalizer: RTL and testbench
================================

FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all ports are listed below, clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  raw adder result is presented.
REQ-005 in_ready  output  1  block can accept a raw result.
REQ-006 in_sign  input  1  sign of the raw sum.
REQ-007 in_exp  input  8  biased exponent of the raw sum (larger operand exponent).
REQ-008 in_mant  input  25  raw mantissa: bit24 carry-out, bit23 hidden-bit position, bits22:0 fraction.
REQ-009 out  output  32  normalized IEEE-754 single {sign, exp[7:0], frac[22:0]}.
REQ-010 out_valid  output  1  out holds a finished result.
REQ-011 out_ready  input  1  downstream consumes out.

Function
REQ-012 FSM states SHALL be IDLE, NORM and DONE; in_ready SHALL equal (state==IDLE).
REQ-013 IDLE: when in_valid=1, the block SHALL capture sign, exp and mant into working registers and move to NORM; otherwise it stays in IDLE.
REQ-014 NORM, mant==0: move to DONE with result {sign, 8'h00, 23'h0}.
REQ-015 NORM, mant[24]=1: mant>>1 and exp+1 in one cycle; if the new exp==8'hFF, go to DONE with {sign, 8'hFF, 23'h0}; otherwise stay in NORM.
REQ-016 NORM, mant[24:23]==2'b01: go to DONE with {sign, exp, mant[22:0]}.
REQ-017 NORM, mant[24:23]==2'b00: mant<<1 and exp-1 per cycle; if exp is already 8'h01 or 8'h00, go to DONE with flushed signed zero {sign, 31'h0}.
REQ-018 Captured exp==8'hFF SHALL produce {sign, 8'hFF, 23'h0} at the first NORM cycle.
REQ-019 Latency (acceptance edge = E0): out_valid SHALL rise after E1 for an input already normalized or zero, after E2 for a carry, and after E(n+1) for n left shifts (max n=23).
REQ-020 A 5-bit shift counter SHALL force DONE after 24 NORM cycles.
REQ-021 DONE: out_valid=1 and out SHALL hold stable until out_ready=1, then return to IDLE on that edge.
REQ-022 A new input SHALL NOT be accepted on the same edge that DONE is exited.
REQ-023 in_valid asserted outside IDLE SHALL be ignored.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, out=32'h0, out_valid=0, working registers=0 and counter=0, including mid-NORM or mid-DONE; in_ready SHALL be 1 during and after reset.
REQ-025 A transaction interrupted by reset SHALL be discarded with no partial output.

Configuration
REQ-026 Macro FP_NORMALIZER_ROUND_EN: when defined, each right shift SHALL round to nearest-even on the dropped bit (dropped bit 1 and new LSB 1 → increment mantissa). A resulting new carry SHALL cause one more NORM cycle.
REQ-027 When FP_NORMALIZER_ROUND_EN is undefined, the dropped bit SHALL be truncated.

Verification
REQ-028 sign=0, exp=8'h80, mant=25'h0800000 → out=32'h40000000, out_valid after E1.
REQ-029 sign=0, exp=8'h7F, mant=25'h1800000 → out=32'h40400000 after E2; mant=25'h1800003 → 32'h40400002 with ROUND_EN, 32'h40400001 without.
REQ-030 sign=0, exp=8'h85, mant=25'h0000001 → out=32'h37000000 after E24; in_ready=0 throughout.
REQ-031 sign=1, exp=8'h03, mant=25'h0000100 → out=32'h80000000 (flush); exp=8'hFE, mant=25'h1000000 → out=32'h7F800000.
REQ-032 out_ready held 0 for 5 cycles in DONE → out stable, in_ready=0; rst pulsed mid-NORM → out=0, out_valid=0, in_ready=1 immediately.

Source files
------------

// File: rtl/fp_normalizer.sv
// fp_normalizer: post-add normalization of a raw floating-point sum into
// an IEEE-754 single. Carries are shifted right one place per cycle, leading
// zeros are shifted left one place per cycle, and underflow flushes to a
// signed zero. Results are held with a valid/ready handshake.
// Build option: define FP_NORMALIZER_ROUND_EN to round the bit dropped by a
// right shift to nearest-even; otherwise that bit is truncated.
module fp_normalizer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_mant,
    output logic [31:0] out,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  exp_q, exp_d;
    logic [24:0] mant_q, mant_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] out_q, out_d;
    logic        valid_q, valid_d;

    logic [24:0] mantRight;
    logic [7:0]  expUp;

    // Right-shift datapath for a carry-out, with optional round-to-nearest-even
    // on the dropped bit; a rounding overflow shows up as a fresh carry.
    always_comb begin
        mantRight = {1'b0, mant_q[24:1]};
`ifdef FP_NORMALIZER_ROUND_EN
        if (mant_q[0] && mant_q[1]) begin
            mantRight = mantRight + 25'd1;
        end
`endif
        expUp = exp_q + 8'd1;
    end

    // Next-state and result selection: one normalization step per NORM cycle,
    // with the shift counter as a backstop that forces completion.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = in_exp;
                    mant_d  = in_mant;
                    cnt_d   = 5'd0;
                    state_d = NORM;
                end
            end
            NORM: begin
                cnt_d = cnt_q + 5'd1;
                if (exp_q == 8'hFF) begin
                    out_d   = {sign_q, 8'hFF, 23'h0};
                    state_d = DONE;
                end else if (mant_q == 25'd0) begin
                    out_d   = {sign_q, 31'h0};
                    state_d = DONE;
                end else if (mant_q[24]) begin
                    mant_d = mantRight;
                    exp_d  = expUp;
                    if (expUp == 8'hFF) begin
                        out_d   = {sign_q, 8'hFF, 23'h0};
                        state_d = DONE;
                    end
                end else if (mant_q[23]) begin
                    out_d   = {sign_q, exp_q, mant_q[22:0]};
                    state_d = DONE;
                end else if (exp_q <= 8'h01) begin
                    out_d   = {sign_q, 31'h0};
                    state_d = DONE;
                end else begin
                    mant_d = {mant_q[23:0], 1'b0};
                    exp_d  = exp_q - 8'd1;
                end
                if ((state_d == NORM) && (cnt_q == 5'd23)) begin
                    out_d   = {sign_q, 31'h0};
                    state_d = DONE;
                end
                if (state_d == DONE) begin
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and working registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= 8'h00;
            mant_q  <= 25'd0;
            cnt_q   <= 5'd0;
            out_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: scoreboard bench for fp_normalizer. The driver pushes the
// expected word and completion cycle for each accepted input; a separate
// monitor pops and compares whenever a new result appears.
// Honors FP_NORMALIZER_ROUND_EN in its reference model and directed vectors.
module tb_fp_normalizer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready;

    typedef struct {
        logic [31:0] val;
        int          due;
    } expect_t;

    expect_t     sbQ[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          stallReq = 0;
    logic        prevValid = 1'b0;
    logic [31:0] prevOut = 32'h0;

    fp_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure result latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: closed-form result and cycles-to-valid from the rules.
    function automatic void refModel(input logic s, input logic [7:0] e, input logic [24:0] m,
                                     output logic [31:0] o, output int lat);
        int ex;
        int n;
        int k;
        int p;
        logic [24:0] mm;
        ex = int'(e);
        if (ex == 255) begin
            o = {s, 8'hFF, 23'h0}; lat = 1; return;
        end
        if (m == 25'd0) begin
            o = {s, 31'h0}; lat = 1; return;
        end
        if (m[24]) begin
            ex = ex + 1;
            if (ex == 255) begin
                o = {s, 8'hFF, 23'h0}; lat = 1; return;
            end
            mm = m >> 1;
`ifdef FP_NORMALIZER_ROUND_EN
            if (m[0] && m[1]) mm = mm + 25'd1;
`endif
            if (mm[24]) begin
                ex = ex + 1;
                if (ex == 255) begin
                    o = {s, 8'hFF, 23'h0}; lat = 2; return;
                end
                o = {s, 8'(ex), 23'h0}; lat = 3; return;
            end
            o = {s, 8'(ex), mm[22:0]}; lat = 2; return;
        end
        p = 0;
        for (int i = 0; i < 24; i++) if (m[i]) p = i;
        n = 23 - p;
        k = (ex > 1) ? ex - 1 : 0;
        if (n <= k) begin
            mm  = m << n;
            o   = {s, 8'(ex - n), mm[22:0]};
            lat = n + 1;
        end else begin
            o   = {s, 31'h0};
            lat = k + 1;
        end
    endfunction

    // Downstream: random backpressure, with an optional forced stall in DONE.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (stallReq > 0 && out_valid) begin
                out_ready = 1'b0;
                stallReq--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: compare each new result against the scoreboard and check that
    // a held result stays stable.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && !prevValid) begin
                    if (sbQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_output actual=%h required=none", out);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("result", out, e.val);
                        checkOutput("latency_cycle", 32'(cyc), 32'(e.due));
                    end
                end else if (out_valid && prevValid) begin
                    checkOutput("hold_stable", out, prevOut);
                end
            end
            prevValid = out_valid;
            prevOut   = out;
        end
    end

    // Issue one input, push its expectation, then shadow it until it retires,
    // injecting ignored garbage inputs while the block is busy.
    task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [24:0] m,
                                 input logic [31:0] expOut, input int lat);
        expect_t item;
        bit sawValid;
        bit done;
        int waitCnt;
        waitCnt = 0;
        while (!in_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_ready actual=%b required=1", in_ready);
            return;
        end
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        @(posedge clk);
        #1;
        item.val = expOut;
        item.due = cyc + lat;
        sbQ.push_back(item);
        sawValid = 1'b0;
        done     = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (!sawValid && !out_valid) begin
                checkOutput("ready_low_busy", {31'h0, in_ready}, 32'h0);
                in_valid = 1'b1;
                in_sign  = 1'($urandom);
                in_exp   = 8'($urandom);
                in_mant  = 25'($urandom);
            end else if (out_valid) begin
                sawValid = 1'b1;
                in_valid = 1'b0;
                checkOutput("ready_low_done", {31'h0, in_ready}, 32'h0);
            end else begin
                in_valid = 1'b0;
                checkOutput("ready_after_done", {31'h0, in_ready}, 32'h1);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL retire_timeout actual=busy required=idle");
        end
    endtask

    // Main sequence: reset, directed vectors, reset mid-flight, random traffic.
    initial begin
        logic [31:0] o;
        int          lat;
        logic        s;
        logic [7:0]  e;
        logic [24:0] m;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sign  = 1'b0;
        in_exp   = 8'h00;
        in_mant  = 25'd0;
        #1 rst = 1'b1;
        #1;
        checkOutput("reset_out", out, 32'h0);
        checkOutput("reset_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("reset_ready", {31'h0, in_ready}, 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(1'b0, 8'h80, 25'h0800000, 32'h40000000, 1);
        stallReq = 5;
        applyStimulus(1'b0, 8'h7F, 25'h1800000, 32'h40400000, 2);
`ifdef FP_NORMALIZER_ROUND_EN
        applyStimulus(1'b0, 8'h7F, 25'h1800003, 32'h40400002, 2);
        applyStimulus(1'b0, 8'h10, 25'h1FFFFFF, 32'h09000000, 3);
`else
        applyStimulus(1'b0, 8'h7F, 25'h1800003, 32'h40400001, 2);
        applyStimulus(1'b0, 8'h10, 25'h1FFFFFF, 32'h08FFFFFF, 2);
`endif
        applyStimulus(1'b0, 8'h85, 25'h0000001, 32'h37000000, 24);
        applyStimulus(1'b1, 8'h03, 25'h0000100, 32'h80000000, 3);
        applyStimulus(1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 1);
        applyStimulus(1'b1, 8'hFF, 25'h0800000, 32'hFF800000, 1);
        applyStimulus(1'b1, 8'h40, 25'h0000000, 32'h80000000, 1);

        // Reset in the middle of a long left-shift run: nothing may emerge.
        in_valid = 1'b1;
        in_sign  = 1'b0;
        in_exp   = 8'h85;
        in_mant  = 25'h0000001;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midnorm_rst_out", out, 32'h0);
        checkOutput("midnorm_rst_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("midnorm_rst_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("discarded_valid", {31'h0, out_valid}, 32'h0);

        for (int t = 0; t < 60; t++) begin
            s = 1'($urandom);
            case ($urandom_range(0, 5))
                0: e = 8'h00;
                1: e = 8'h01;
                2: e = 8'hFE;
                3: e = 8'hFF;
                default: e = 8'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: m = 25'd0;
                1: m = {1'b1, 24'($urandom)};
                2: m = {2'b01, 23'($urandom)};
                default: m = {1'b0, 24'($urandom)} >> $urandom_range(0, 24);
            endcase
            refModel(s, e, m, o, lat);
            applyStimulus(s, e, m, o, lat);
        end

        for (int w = 0; w < 200 && sbQ.size() != 0; w++) @(negedge clk);
        if (sbQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_scoreboard actual=%0d required=0", sbQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
